// File: rtl/filter_ewma_mc.sv
// filter_ewma_mc: multi-channel, multi-pole EWMA filter for the voice mixing path.
// A single time-shared multiplier walks every (channel, stage) pair of a frame,
// one update per clock, then publishes the whole frame as either the low-pass
// result of the last pole or the high-pass residue (input minus last pole).
module filter_ewma_mc #(
  parameter int DATA_BITS = 12,
  parameter int CHANNELS  = 4,
  parameter int STAGES    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          din_valid,
  input  logic [CHANNELS*DATA_BITS-1:0] din,
  input  logic [8:0]                    alpha,
  input  logic                          hp_mode,
  output logic [CHANNELS*DATA_BITS-1:0] dout,
  output logic                          dout_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int NUM_REGS = CHANNELS * STAGES;
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW       = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int PW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int PRODW    = DATA_BITS + 11;

  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);
  localparam logic [SW-1:0] LAST_ST = SW'(STAGES - 1);

  // Flipping the MSB converts between offset-binary and two's complement.
  localparam logic [DATA_BITS-1:0] MID_SCALE = {1'b1, {(DATA_BITS-1){1'b0}}};
  localparam logic signed [DATA_BITS-1:0] SAT_MAX = {1'b0, {(DATA_BITS-1){1'b1}}};
  localparam logic signed [DATA_BITS-1:0] SAT_MIN = {1'b1, {(DATA_BITS-1){1'b0}}};
  localparam logic [8:0] ALPHA_UNITY = 9'd256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsmState_t;

  fsmState_t fsm_q, fsm_d;

  logic [CW-1:0] chIdx_q, chIdx_d;
  logic [SW-1:0] stIdx_q, stIdx_d;
  logic [PW-1:0] ptr_q, ptr_d;

  logic signed [DATA_BITS-1:0] mem_q   [NUM_REGS];
  logic signed [DATA_BITS-1:0] inLat_q [CHANNELS];
  logic [8:0]                  alphaLat_q;
  logic                        hpLat_q;

  logic [CHANNELS*DATA_BITS-1:0] dout_q, doutNext;
  logic                          doutValid_q;
  logic                          overrun_q;

  logic acceptFrame;
  logic doUpdate;
  logic loadOut;
  logic lastUpdate;
  logic [8:0] alphaClamped;

  logic signed [DATA_BITS-1:0] xIn;
  logic signed [DATA_BITS-1:0] yCur;
  logic signed [DATA_BITS:0]   diff;
  logic signed [PRODW-1:0]     prod;
  logic signed [PRODW-1:0]     shifted;
  logic signed [DATA_BITS-1:0] yNew;
  logic                        unusedBits;

  // Coefficients above unity would overshoot the input, so they saturate at 256.
  assign alphaClamped = (alpha > ALPHA_UNITY) ? ALPHA_UNITY : alpha;
  assign lastUpdate   = (chIdx_q == LAST_CH) && (stIdx_q == LAST_ST);

  // FSM state register; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next-state: accept in IDLE, sweep all updates in RUN, publish in DONE.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (din_valid) fsm_d = RUN;
      RUN:     if (lastUpdate) fsm_d = DONE;
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // FSM outputs: strobes that steer the datapath for the current state.
  always_comb begin
    busy        = 1'b0;
    acceptFrame = 1'b0;
    doUpdate    = 1'b0;
    loadOut     = 1'b0;
    case (fsm_q)
      IDLE: acceptFrame = din_valid;
      RUN: begin
        busy     = 1'b1;
        doUpdate = 1'b1;
      end
      DONE: begin
        busy    = 1'b1;
        loadOut = 1'b1;
      end
      default: ;
    endcase
  end

  // Walk channel-major / stage-minor; ptr tracks the flat state-memory index.
  always_comb begin
    chIdx_d = chIdx_q;
    stIdx_d = stIdx_q;
    ptr_d   = ptr_q;
    if (acceptFrame) begin
      chIdx_d = '0;
      stIdx_d = '0;
      ptr_d   = '0;
    end else if (doUpdate) begin
      ptr_d = ptr_q + 1'b1;
      if (stIdx_q == LAST_ST) begin
        stIdx_d = '0;
        chIdx_d = chIdx_q + 1'b1;
      end else begin
        stIdx_d = stIdx_q + 1'b1;
      end
    end
  end

  // One EWMA step: stage 0 sees the frame input, later stages see the
  // previous stage, which has already been updated earlier in this frame.
  always_comb begin
    if (stIdx_q == '0) begin
      xIn = inLat_q[chIdx_q];
    end else begin
      xIn = mem_q[ptr_q - 1'b1];
    end
    yCur    = mem_q[ptr_q];
    diff    = {xIn[DATA_BITS-1], xIn} - {yCur[DATA_BITS-1], yCur};
    prod    = $signed({{10{diff[DATA_BITS]}}, diff}) *
              $signed({{(DATA_BITS+2){1'b0}}, alphaLat_q});
    shifted = prod >>> 8;
    yNew    = yCur + $signed(shifted[DATA_BITS-1:0]);
  end

  // The step never leaves [y, x], so the high bits of the scaled delta are redundant.
  assign unusedBits = ^shifted[PRODW-1:DATA_BITS];

  // Per-channel output formatting: low-pass last pole or saturated high-pass residue.
  for (genvar c = 0; c < CHANNELS; c++) begin : gOut
    logic signed [DATA_BITS-1:0] lastStage;
    logic signed [DATA_BITS:0]   hDiff;
    logic signed [DATA_BITS-1:0] hSat;
    logic signed [DATA_BITS-1:0] outSigned;

    // Compute the signed output word for this channel before MSB re-inversion.
    always_comb begin
      lastStage = mem_q[c*STAGES + STAGES - 1];
      hDiff     = {inLat_q[c][DATA_BITS-1], inLat_q[c]} -
                  {lastStage[DATA_BITS-1], lastStage};
      if (hDiff[DATA_BITS] != hDiff[DATA_BITS-1]) begin
        hSat = hDiff[DATA_BITS] ? SAT_MIN : SAT_MAX;
      end else begin
        hSat = hDiff[DATA_BITS-1:0];
      end
      outSigned = hpLat_q ? hSat : lastStage;
    end

    assign doutNext[c*DATA_BITS +: DATA_BITS] = outSigned ^ MID_SCALE;
  end

  // Frame bookkeeping: capture inputs at acceptance and advance the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chIdx_q    <= '0;
      stIdx_q    <= '0;
      ptr_q      <= '0;
      alphaLat_q <= '0;
      hpLat_q    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) inLat_q[i] <= '0;
    end else begin
      chIdx_q <= chIdx_d;
      stIdx_q <= stIdx_d;
      ptr_q   <= ptr_d;
      if (acceptFrame) begin
        alphaLat_q <= alphaClamped;
        hpLat_q    <= hp_mode;
        for (int i = 0; i < CHANNELS; i++) begin
          inLat_q[i] <= din[i*DATA_BITS +: DATA_BITS] ^ MID_SCALE;
        end
      end
    end
  end

  // Filter state memory; only the pole currently addressed is rewritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (doUpdate) begin
      mem_q[ptr_q] <= yNew;
    end
  end

  // Output registers: dout holds between frames; valid and overrun are one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q      <= {CHANNELS{MID_SCALE}};
      doutValid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      doutValid_q <= loadOut;
      overrun_q   <= din_valid && busy;
      if (loadOut) begin
        dout_q <= doutNext;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = doutValid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_filter_ewma_mc.sv
// tb_filter_ewma_mc: directed self-checking bench for filter_ewma_mc with
// hand-computed expected frames (DATA_BITS=12, CHANNELS=4, STAGES=2).
module tb_filter_ewma_mc;

  logic        clk;
  logic        rst;
  logic        din_valid;
  logic [47:0] din;
  logic [8:0]  alpha;
  logic        hp_mode;
  logic [47:0] dout;
  logic        dout_valid;
  logic        busy;
  logic        overrun;

  int checks;
  int errors;
  int lat;
  int busyCnt;
  int ovCnt;
  int vldCnt;
  logic [11:0] expV [4];

  filter_ewma_mc #(
    .DATA_BITS(12),
    .CHANNELS (4),
    .STAGES   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .alpha     (alpha),
    .hp_mode   (hp_mode),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse reset over a couple of edges and release it on a falling edge.
  task automatic applyReset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic setFrame(input logic [11:0] c0, input logic [11:0] c1,
                          input logic [11:0] c2, input logic [11:0] c3);
    din = {c3, c2, c1, c0};
  endtask

  // Raise din_valid for one edge; returns #1 after the accepting edge.
  task automatic startFrame;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  // Bounded wait for dout_valid, measuring latency, busy cycles and overruns.
  task automatic waitDone;
    lat     = 0;
    busyCnt = busy ? 1 : 0;
    ovCnt   = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (busy) busyCnt++;
      if (overrun) ovCnt++;
      if (dout_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dout !== {4{12'd2048}}) begin
      errors++;
      $display("[TB] FAIL reset_dout: got %h expected %h", dout, {4{12'd2048}});
    end
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got valid=%b busy=%b ovr=%b expected 0 0 0",
               dout_valid, busy, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unity;
    applyReset();
    alpha = 9'd256; hp_mode = 1'b0;
    setFrame(12'd3000, 12'd100, 12'd4095, 12'd0);
    @(negedge clk);
    startFrame();
    waitDone();
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("[TB] FAIL unity_latency: got %0d expected 9", lat);
    end
    checks++;
    if (busyCnt !== 9) begin
      errors++;
      $display("[TB] FAIL unity_busy_cycles: got %0d expected 9", busyCnt);
    end
    expV[0] = 12'd3000; expV[1] = 12'd100; expV[2] = 12'd4095; expV[3] = 12'd0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (dout[c*12 +: 12] !== expV[c]) begin
        errors++;
        $display("[TB] FAIL unity_ch%0d: got %0d expected %0d", c, dout[c*12 +: 12], expV[c]);
      end
    end
  endtask

  task automatic test_half;
    applyReset();
    alpha = 9'd128; hp_mode = 1'b0;
    setFrame(12'd3072, 12'd3072, 12'd3072, 12'd3072);
    @(negedge clk);
    startFrame();
    waitDone();
    checks++;
    if (lat !== 9 || dout !== {4{12'd2304}}) begin
      errors++;
      $display("[TB] FAIL half_lp: got lat=%0d dout=%h expected lat=9 dout=%h",
               lat, dout, {4{12'd2304}});
    end
    hp_mode = 1'b1;
    @(negedge clk);
    startFrame();
    waitDone();
    checks++;
    if (lat !== 9 || dout !== {4{12'd2560}}) begin
      errors++;
      $display("[TB] FAIL half_hp: got lat=%0d dout=%h expected lat=9 dout=%h",
               lat, dout, {4{12'd2560}});
    end
  endtask

  task automatic test_floor;
    applyReset();
    alpha = 9'd1; hp_mode = 1'b0;
    setFrame(12'd2047, 12'd2047, 12'd2047, 12'd2047);
    @(negedge clk);
    startFrame();
    waitDone();
    checks++;
    if (dout !== {4{12'd2047}}) begin
      errors++;
      $display("[TB] FAIL floor_neg: got %h expected %h", dout, {4{12'd2047}});
    end
    applyReset();
    setFrame(12'd2049, 12'd2049, 12'd2049, 12'd2049);
    @(negedge clk);
    startFrame();
    waitDone();
    checks++;
    if (lat !== 9 || dout !== {4{12'd2048}}) begin
      errors++;
      $display("[TB] FAIL floor_pos: got lat=%0d dout=%h expected lat=9 dout=%h",
               lat, dout, {4{12'd2048}});
    end
  endtask

  task automatic test_hp_saturation;
    applyReset();
    alpha = 9'd256; hp_mode = 1'b0;
    setFrame(12'd0, 12'd0, 12'd0, 12'd0);
    @(negedge clk);
    startFrame();
    waitDone();
    checks++;
    if (dout !== {4{12'd0}}) begin
      errors++;
      $display("[TB] FAIL hpsat_prime: got %h expected %h", dout, {4{12'd0}});
    end
    alpha = 9'd0; hp_mode = 1'b1;
    setFrame(12'd4095, 12'd4095, 12'd4095, 12'd4095);
    @(negedge clk);
    startFrame();
    waitDone();
    checks++;
    if (lat !== 9 || dout !== {4{12'd4095}}) begin
      errors++;
      $display("[TB] FAIL hpsat_out: got lat=%0d dout=%h expected lat=9 dout=%h",
               lat, dout, {4{12'd4095}});
    end
  endtask

  task automatic test_overrun;
    applyReset();
    alpha = 9'd256; hp_mode = 1'b0;
    setFrame(12'd1000, 12'd2000, 12'd3000, 12'd4000);
    @(negedge clk);
    startFrame();
    ovCnt = 0; vldCnt = 0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin
        din_valid = 1'b1;
        din       = '0;
      end
      if (i == 3) din_valid = 1'b0;
      if (overrun) ovCnt++;
      if (dout_valid) begin
        vldCnt++;
        if (lat == 0) lat = i;
      end
    end
    din_valid = 1'b0;
    checks++;
    if (ovCnt !== 1) begin
      errors++;
      $display("[TB] FAIL overrun_pulses: got %0d expected 1", ovCnt);
    end
    checks++;
    if (vldCnt !== 1 || lat !== 9) begin
      errors++;
      $display("[TB] FAIL overrun_frames: got valids=%0d lat=%0d expected valids=1 lat=9",
               vldCnt, lat);
    end
    expV[0] = 12'd1000; expV[1] = 12'd2000; expV[2] = 12'd3000; expV[3] = 12'd4000;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (dout[c*12 +: 12] !== expV[c]) begin
        errors++;
        $display("[TB] FAIL overrun_ch%0d: got %0d expected %0d", c, dout[c*12 +: 12], expV[c]);
      end
    end
  endtask

  task automatic test_alpha_clamp;
    applyReset();
    alpha = 9'd300; hp_mode = 1'b0;
    setFrame(12'd3000, 12'd100, 12'd4095, 12'd0);
    @(negedge clk);
    startFrame();
    waitDone();
    expV[0] = 12'd3000; expV[1] = 12'd100; expV[2] = 12'd4095; expV[3] = 12'd0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (dout[c*12 +: 12] !== expV[c]) begin
        errors++;
        $display("[TB] FAIL clamp_ch%0d: got %0d expected %0d", c, dout[c*12 +: 12], expV[c]);
      end
    end
  endtask

  task automatic test_back_to_back;
    applyReset();
    alpha = 9'd128; hp_mode = 1'b0;
    setFrame(12'd3072, 12'd3072, 12'd3072, 12'd3072);
    @(negedge clk);
    startFrame();
    waitDone();
    checks++;
    if (dout_valid !== 1'b1 || busy !== 1'b0 || dout !== {4{12'd2304}}) begin
      errors++;
      $display("[TB] FAIL b2b_first: got valid=%b busy=%b dout=%h expected 1 0 %h",
               dout_valid, busy, dout, {4{12'd2304}});
    end
    startFrame();
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got ovr=%b busy=%b expected 0 1", overrun, busy);
    end
    waitDone();
    checks++;
    if (lat !== 9 || ovCnt !== 0 || dout !== {4{12'd2560}}) begin
      errors++;
      $display("[TB] FAIL b2b_second: got lat=%0d ovr=%0d dout=%h expected 9 0 %h",
               lat, ovCnt, dout, {4{12'd2560}});
    end
  endtask

  task automatic test_reset_mid_run;
    applyReset();
    alpha = 9'd256; hp_mode = 1'b0;
    setFrame(12'd4095, 12'd4095, 12'd4095, 12'd4095);
    @(negedge clk);
    startFrame();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0 || dout !== {4{12'd2048}}) begin
      errors++;
      $display("[TB] FAIL midrst_async: got busy=%b valid=%b dout=%h expected 0 0 %h",
               busy, dout_valid, dout, {4{12'd2048}});
    end
    @(negedge clk);
    rst = 1'b0;
    vldCnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (dout_valid) vldCnt++;
    end
    checks++;
    if (vldCnt !== 0 || dout !== {4{12'd2048}}) begin
      errors++;
      $display("[TB] FAIL midrst_abort: got valids=%0d dout=%h expected 0 %h",
               vldCnt, dout, {4{12'd2048}});
    end
  endtask

  // Run every scenario in order, then report the totals.
  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    alpha     = '0;
    hp_mode   = 1'b0;
    test_reset();
    test_unity();
    test_half();
    test_floor();
    test_hp_saturation();
    test_overrun();
    test_alpha_clamp();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
